ifu_fetch_queue: RTL and testbench

//  Instruction-fetch stage directly downstream of the NPC register.
//  - Takes the current PC and issues word reads to instruction memory over a req/gnt/rvalid handshake.
//  - Buffers returned {pc, instr} pairs in a small in-order FIFO and feeds decode over a valid/ready interface.
//  - Back-pressures the NPC with fetch_stall and discards stale fetches on a redirect (flush).

---
 rtl/ifu_fetch_queue_if.sv | 51 +++++
 rtl/ifu_fetch_queue.sv | 194 +++++++++++++++++++
 tb/tb_ifu_fetch_queue.sv | 357 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ifu_fetch_queue_if.sv
// ifu_fetch_queue_if
// Groups the handshakes around the instruction-fetch queue.
// The instruction-memory read channel and the decode-side valid/ready stream
// are both bundled here.
//   imem_req / imem_addr        : word read request towards instruction memory
//   imem_gnt                    : memory accepted the request this cycle
//   imem_rvalid / imem_rdata    : in-order read response
//   dec_valid / dec_ready       : head-of-queue handshake with decode
//   dec_pc / dec_instr / dec_adel : contents of the head entry
// Modports:
//   master : the fetch queue itself
//   slave  : the memory and decode side facing the queue
interface ifu_fetch_queue_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;

    logic        dec_valid;
    logic        dec_ready;
    logic [31:0] dec_pc;
    logic [31:0] dec_instr;
    logic        dec_adel;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_gnt,
        input  imem_rvalid,
        input  imem_rdata,
        output dec_valid,
        input  dec_ready,
        output dec_pc,
        output dec_instr,
        output dec_adel
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_gnt,
        output imem_rvalid,
        output imem_rdata,
        input  dec_valid,
        output dec_ready,
        input  dec_pc,
        input  dec_instr,
        input  dec_adel
    );
endinterface

// File: rtl/ifu_fetch_queue.sv
// ifu_fetch_queue
// Instruction-fetch stage sitting directly behind the NPC register.
// It issues one word read at a time for the current PC. Returned {pc, instr}
// pairs are buffered in a small in-order show-ahead FIFO that feeds decode.
// The NPC is held with fetch_stall until the PC has been consumed. A redirect
// (flush) empties the FIFO, and any fetch still in flight is thrown away.
// Ports:
//   clk          : single clock, all state on the rising edge
//   reset        : synchronous, active-high
//   fetch_pc     : current PC from the NPC register
//   fetch_stall  : 1 = NPC must hold its PC this cycle
//   flush        : redirect, NPC loads a new target this cycle
//   bus (master) : imem req/gnt/rvalid channel plus decode valid/ready stream
// Parameter:
//   DEPTH        : FIFO entries, power of two and at least 2
module ifu_fetch_queue #(
    parameter int DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [31:0]       fetch_pc,
    output logic              fetch_stall,
    input  logic              flush,
    ifu_fetch_queue_if.master bus
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);
    localparam logic [PW-1:0] PTR_ONE = PW'(1);

    // IDLE: free to issue, WAIT: one response owed and kept,
    // DROP: one response owed that belongs to a flushed path
    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_DROP
    } state_t;

    state_t state;
    state_t state_next;

    logic [31:0] pc_q;

    logic [31:0] fifo_pc    [DEPTH];
    logic [31:0] fifo_instr [DEPTH];
    logic        fifo_adel  [DEPTH];

    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] count;

    logic        room;
    logic        misaligned;
    logic        in_idle;
    logic        grant;
    logic        push;
    logic        pop;
    logic [31:0] push_pc;
    logic [31:0] push_instr;
    logic        push_adel;

    // A free slot is required before issuing. That slot stays reserved for
    // the whole WAIT period because nothing else pushes outside IDLE.
    assign misaligned = (fetch_pc[1:0] != 2'b00);
    assign room       = (count < DEPTH_C);
    assign in_idle    = (state == S_IDLE);

    // Misaligned PCs never reach memory. The request is also held low
    // during reset so nothing is issued towards a memory that is itself
    // resetting.
    assign bus.imem_req  = in_idle && !flush && room && !misaligned && !reset;
    assign bus.imem_addr = fetch_pc;
    assign grant         = bus.imem_req && bus.imem_gnt;

    // The PC moves on a grant or a misaligned push, and always on a redirect.
    // grant already covers the IDLE/room/aligned terms, so using it here is
    // equivalent to using the raw gnt.
    assign fetch_stall = !flush && !(in_idle && room && (grant || misaligned));

    // Select what (if anything) gets written into the FIFO this cycle.
    // A redirect suppresses every push. The memory response and the
    // misaligned push cannot collide because one needs WAIT and the other
    // needs IDLE.
    always_comb begin
        push       = 1'b0;
        push_pc    = pc_q;
        push_instr = bus.imem_rdata;
        push_adel  = 1'b0;
        if (!flush) begin
            if ((state == S_WAIT) && bus.imem_rvalid) begin
                push = 1'b1;
            end else if (in_idle && room && misaligned) begin
                push       = 1'b1;
                push_pc    = fetch_pc;
                push_instr = 32'h0;
                push_adel  = 1'b1;
            end
        end
    end

    // A redirect also wins over a pop in the same cycle.
    assign pop = bus.dec_valid && bus.dec_ready && !flush;

    // Next-state logic. An rvalid always returns the FSM to IDLE, whether
    // the data is kept or discarded. A flush without rvalid while waiting
    // turns the outstanding fetch into one that must be dropped.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (grant) begin
                    state_next = S_WAIT;
                end
            end
            S_WAIT: begin
                if (bus.imem_rvalid) begin
                    state_next = S_IDLE;
                end else if (flush) begin
                    state_next = S_DROP;
                end
            end
            S_DROP: begin
                if (bus.imem_rvalid) begin
                    state_next = S_IDLE;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Remember which PC the outstanding request belongs to, so the
    // returned word can be paired with it.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q <= 32'h0;
        end else if (grant) begin
            pc_q <= fetch_pc;
        end
    end

    // FIFO bookkeeping. Pointers wrap naturally at DEPTH because they are
    // exactly log2(DEPTH) bits wide. A simultaneous push and pop leaves the
    // occupancy unchanged.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    // Storage array. It is left unreset because the occupancy counter alone
    // decides which entries are meaningful.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_pc[wr_ptr]    <= push_pc;
            fifo_instr[wr_ptr] <= push_instr;
            fifo_adel[wr_ptr]  <= push_adel;
        end
    end

    // Show-ahead head. The data fields are forced to zero while empty so
    // decode never sees stale contents after reset or a redirect.
    assign bus.dec_valid = (count != '0);
    assign bus.dec_pc    = bus.dec_valid ? fifo_pc[rd_ptr]    : 32'h0;
    assign bus.dec_instr = bus.dec_valid ? fifo_instr[rd_ptr] : 32'h0;
    assign bus.dec_adel  = bus.dec_valid ? fifo_adel[rd_ptr]  : 1'b0;

endmodule

// File: tb/tb_ifu_fetch_queue.sv
// tb_ifu_fetch_queue
// Directed scenarios followed by a randomized phase for ifu_fetch_queue.
// Expected outputs come from a behavioural model that keeps three things:
// a queue of {pc, instr, adel} entries, an "outstanding fetch" flag with a
// discard marker, and an in-order instruction memory that answers each
// granted request after a configurable latency. The bench also acts as the
// NPC: it advances the PC when no stall is expected and loads the redirect
// target on a flush.
module tb_ifu_fetch_queue;

    localparam int DEPTH = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_3000;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        adel;
    } entry_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    logic        fetch_stall;
    logic [31:0] fetch_pc;

    ifu_fetch_queue_if bus ();

    ifu_fetch_queue #(.DEPTH(DEPTH)) dut (
        .clk         (clk),
        .reset       (reset),
        .fetch_pc    (fetch_pc),
        .fetch_stall (fetch_stall),
        .flush       (flush),
        .bus         (bus)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    int grants      = 0;

    // reference model state
    entry_t      exp_q[$];
    logic        m_busy;
    logic        m_discard;
    logic [31:0] m_pc;
    logic [31:0] npc;

    // memory responder
    logic        mem_busy;
    int          mem_wait;
    logic [31:0] mem_addr;
    int          lat_min;
    int          lat_max;
    logic        gnt_en;
    logic        rand_gnt;

    // observations kept for scenario-level checks
    logic [31:0] pop_pc[$];
    logic [31:0] pop_instr[$];
    logic        pop_adel[$];
    int          pop_cyc[$];
    logic        last_req;
    logic        last_stall;
    logic        last_valid;
    logic [31:0] last_addr;
    logic [31:0] first_addr;

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return a ^ 32'hC0DE_0000 ^ {a[7:0], 24'h0};
    endfunction

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic clear_log();
        pop_pc.delete();
        pop_instr.delete();
        pop_adel.delete();
        pop_cyc.delete();
        grants = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset           = 1'b1;
        flush           = 1'b0;
        bus.imem_gnt    = 1'b0;
        bus.imem_rvalid = 1'b0;
        bus.imem_rdata  = 32'h0;
        bus.dec_ready   = 1'b0;
        fetch_pc        = RESET_PC;
        @(posedge clk);
        @(negedge clk);
        #1;
        check_output("rst_dec_valid", 32'(bus.dec_valid), 32'd0);
        check_output("rst_dec_pc",    bus.dec_pc,          32'd0);
        check_output("rst_dec_instr", bus.dec_instr,       32'd0);
        check_output("rst_dec_adel",  32'(bus.dec_adel),   32'd0);
        check_output("rst_imem_req",  32'(bus.imem_req),   32'd0);
        reset = 1'b0;
        exp_q.delete();
        m_busy    = 1'b0;
        m_discard = 1'b0;
        mem_busy  = 1'b0;
        mem_wait  = 0;
        npc       = RESET_PC;
        clear_log();
    endtask

    // One clock cycle: drive inputs, compare against the model, clock, and
    // advance the model.
    task automatic apply_stimulus(input logic do_flush, input logic [31:0] target, input logic ready);
        logic        g;
        logic        rv;
        logic        room;
        logic        mis;
        logic        e_req;
        logic        e_stall;
        logic        e_valid;
        logic [31:0] rd;
        entry_t      head;
        entry_t      gone;

        @(negedge clk);
        fetch_pc = npc;
        g  = rand_gnt ? 1'($urandom_range(0, 1)) : gnt_en;
        rv = mem_busy && (mem_wait == 0);
        rd = rv ? instr_of(mem_addr) : $urandom;
        flush           = do_flush;
        bus.dec_ready   = ready;
        bus.imem_gnt    = g;
        bus.imem_rvalid = rv;
        bus.imem_rdata  = rd;
        #1;

        room    = (exp_q.size() < DEPTH);
        mis     = (fetch_pc[1:0] != 2'b00);
        e_req   = !m_busy && !do_flush && room && !mis;
        e_stall = !do_flush && !(!m_busy && room && (g || mis));
        e_valid = (exp_q.size() != 0);
        head    = e_valid ? exp_q[0] : '0;

        check_output("imem_req",    32'(bus.imem_req),  32'(e_req));
        check_output("imem_addr",   bus.imem_addr,      fetch_pc);
        check_output("fetch_stall", 32'(fetch_stall),   32'(e_stall));
        check_output("dec_valid",   32'(bus.dec_valid), 32'(e_valid));
        check_output("dec_pc",      bus.dec_pc,         head.pc);
        check_output("dec_instr",   bus.dec_instr,      head.instr);
        check_output("dec_adel",    32'(bus.dec_adel),  32'(head.adel));

        last_req   = bus.imem_req;
        last_stall = fetch_stall;
        last_valid = bus.dec_valid;
        last_addr  = bus.imem_addr;
        if (bus.imem_req && g) begin
            grants++;
        end
        if (bus.dec_valid && ready && !do_flush) begin
            pop_pc.push_back(bus.dec_pc);
            pop_instr.push_back(bus.dec_instr);
            pop_adel.push_back(bus.dec_adel);
            pop_cyc.push_back(cyc);
        end

        @(posedge clk);
        cyc++;

        if (do_flush) begin
            exp_q.delete();
        end else begin
            if (e_valid && ready) begin
                gone = exp_q.pop_front();
            end
            if (!m_busy && room && mis) begin
                exp_q.push_back('{pc: fetch_pc, instr: 32'h0, adel: 1'b1});
            end
            if (m_busy && !m_discard && rv) begin
                exp_q.push_back('{pc: m_pc, instr: rd, adel: 1'b0});
            end
        end

        if (m_busy) begin
            if (rv) begin
                m_busy = 1'b0;
            end else if (do_flush) begin
                m_discard = 1'b1;
            end
        end else if (e_req && g) begin
            m_busy    = 1'b1;
            m_discard = 1'b0;
            m_pc      = fetch_pc;
        end

        if (mem_busy) begin
            if (mem_wait == 0) begin
                mem_busy = 1'b0;
            end else begin
                mem_wait--;
            end
        end else if (e_req && g) begin
            mem_busy = 1'b1;
            mem_wait = $urandom_range(lat_max, lat_min);
            mem_addr = fetch_pc;
        end

        if (do_flush) begin
            npc = target;
        end else if (!e_stall) begin
            npc = fetch_pc + 32'd4;
        end
    endtask

    initial begin
        reset           = 1'b1;
        flush           = 1'b0;
        fetch_pc        = RESET_PC;
        bus.imem_gnt    = 1'b0;
        bus.imem_rvalid = 1'b0;
        bus.imem_rdata  = 32'h0;
        bus.dec_ready   = 1'b0;
        rand_gnt        = 1'b0;
        gnt_en          = 1'b1;
        lat_min         = 0;
        lat_max         = 0;

        $display("[TB] step 1: streaming fetch, gnt=1, 1-cycle rvalid");
        do_reset();
        for (int i = 0; i < 8; i++) begin
            apply_stimulus(1'b0, 32'h0, 1'b1);
            if (i == 0) begin
                first_addr = last_addr;
            end
        end
        check_output("t1_first_addr", first_addr, RESET_PC);
        check_output("t1_pop_count", 32'(pop_pc.size()), 32'd3);
        for (int i = 0; i < 3; i++) begin
            check_output("t1_pop_pc", (pop_pc.size() > i) ? pop_pc[i] : 32'hx, RESET_PC + 32'(4 * i));
            check_output("t1_pop_gap", (pop_cyc.size() > i) ? 32'(pop_cyc[i] - pop_cyc[0]) : 32'hx, 32'(2 * i));
        end

        $display("[TB] step 2: decode blocked, FIFO fills then drains");
        do_reset();
        for (int i = 0; i < 12; i++) begin
            apply_stimulus(1'b0, 32'h0, 1'b0);
        end
        check_output("t2_grants", 32'(grants), 32'd4);
        check_output("t2_stall_full", 32'(last_stall), 32'd1);
        check_output("t2_req_full", 32'(last_req), 32'd0);
        clear_log();
        gnt_en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            apply_stimulus(1'b0, 32'h0, 1'b1);
        end
        check_output("t2_drain_count", 32'(pop_pc.size()), 32'd4);
        for (int i = 0; i < 4; i++) begin
            check_output("t2_drain_pc", (pop_pc.size() > i) ? pop_pc[i] : 32'hx, RESET_PC + 32'(4 * i));
        end

        $display("[TB] step 3: flush while a fetch is outstanding");
        do_reset();
        gnt_en  = 1'b1;
        lat_min = 3;
        lat_max = 3;
        npc     = 32'h0000_3010;
        apply_stimulus(1'b0, 32'h0, 1'b1);
        check_output("t3_granted", 32'(grants), 32'd1);
        gnt_en = 1'b0;
        apply_stimulus(1'b1, 32'h0000_3100, 1'b1);
        for (int i = 0; i < 3; i++) begin
            apply_stimulus(1'b0, 32'h0, 1'b1);
        end
        check_output("t3_fifo_empty", 32'(last_valid), 32'd0);
        gnt_en = 1'b1;
        apply_stimulus(1'b0, 32'h0, 1'b1);
        check_output("t3_redirect_addr", last_addr, 32'h0000_3100);
        check_output("t3_redirect_req", 32'(last_req), 32'd1);
        check_output("t3_no_push", 32'(last_valid), 32'd0);

        $display("[TB] step 4: flush together with rvalid and pop");
        do_reset();
        lat_min = 0;
        lat_max = 0;
        for (int i = 0; i < 5; i++) begin
            apply_stimulus(1'b0, 32'h0, 1'b0);
        end
        check_output("t4_two_queued", 32'(last_valid), 32'd1);
        apply_stimulus(1'b1, 32'h0000_3200, 1'b1);
        apply_stimulus(1'b0, 32'h0, 1'b0);
        check_output("t4_empty", 32'(last_valid), 32'd0);
        check_output("t4_idle_req", 32'(last_req), 32'd1);
        check_output("t4_idle_addr", last_addr, 32'h0000_3200);

        $display("[TB] step 5: misaligned PC");
        do_reset();
        npc = 32'h0000_3002;
        apply_stimulus(1'b0, 32'h0, 1'b0);
        check_output("t5_no_req", 32'(last_req), 32'd0);
        apply_stimulus(1'b0, 32'h0, 1'b1);
        check_output("t5_popped", 32'(pop_pc.size()), 32'd1);
        check_output("t5_pc", (pop_pc.size() > 0) ? pop_pc[0] : 32'hx, 32'h0000_3002);
        check_output("t5_instr", (pop_instr.size() > 0) ? pop_instr[0] : 32'hx, 32'h0);
        check_output("t5_adel", (pop_adel.size() > 0) ? 32'(pop_adel[0]) : 32'hx, 32'd1);
        apply_stimulus(1'b1, RESET_PC, 1'b0);

        $display("[TB] step 6: grant withheld, then reset while waiting");
        do_reset();
        gnt_en  = 1'b0;
        lat_min = 3;
        lat_max = 3;
        for (int i = 0; i < 5; i++) begin
            apply_stimulus(1'b0, 32'h0, 1'b1);
            check_output("t6_req_held", 32'(last_req), 32'd1);
            check_output("t6_stall_held", 32'(last_stall), 32'd1);
            check_output("t6_pc_held", last_addr, RESET_PC);
        end
        gnt_en = 1'b1;
        apply_stimulus(1'b0, 32'h0, 1'b1);
        gnt_en = 1'b0;
        apply_stimulus(1'b0, 32'h0, 1'b1);
        check_output("t6_waiting_stall", 32'(last_stall), 32'd1);
        do_reset();
        gnt_en = 1'b1;
        apply_stimulus(1'b0, 32'h0, 1'b1);
        check_output("t6_idle_after_reset", 32'(last_req), 32'd1);
        check_output("t6_empty_after_reset", 32'(last_valid), 32'd0);

        $display("[TB] step 7: randomized traffic");
        do_reset();
        rand_gnt = 1'b1;
        lat_min  = 0;
        lat_max  = 3;
        for (int i = 0; i < 600; i++) begin
            logic        f;
            logic        rdy;
            logic [31:0] t;
            f   = ($urandom_range(0, 99) < 5);
            rdy = ($urandom_range(0, 99) < 70);
            t   = RESET_PC + {22'h0, 8'($urandom_range(0, 255)), 2'b00};
            if ($urandom_range(0, 19) == 0) begin
                t[1:0] = 2'($urandom_range(1, 3));
            end
            apply_stimulus(f, t, rdy);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
